// File: rtl/cmsdk_apb4_eg_arb_pkg.sv
// Shared state encoding and counter sizing for the two-client APB4 arbiter.
package cmsdk_apb4_eg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/cmsdk_apb4_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the client that was not served last.
module cmsdk_apb4_rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        valid = |eligible;
        case (eligible)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmsdk_apb4_eg_arbiter.sv
// Shares one APB4 slave between two req/ack clients with round-robin arbitration.
// Optional ACCESS-phase timeout abort: define APB_ARB_TIMEOUT_EN.
module cmsdk_apb4_eg_arbiter
    import cmsdk_apb4_eg_arb_pkg::*;
#(
    parameter int ADDRWIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 req0,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic                 write0,
    input  logic [31:0]          wdata0,
    input  logic [3:0]           strb0,
    input  logic                 req1,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic                 write1,
    input  logic [31:0]          wdata1,
    input  logic [3:0]           strb1,
    output logic                 ack0,
    output logic [31:0]          rdata0,
    output logic                 err0,
    output logic                 ack1,
    output logic [31:0]          rdata1,
    output logic                 err1,
    output logic                 psel,
    output logic                 penable,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic                 pwrite,
    output logic [31:0]          pwdata,
    output logic [3:0]           pstrb,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    arb_state_t state;

    logic                 grant;
    logic                 last_grant;
    logic                 rr_valid;
    logic                 rr_grant;
    logic [1:0]           eligible;
    logic                 timed_out;
    logic                 finish;
    logic                 cap_err;
    logic [31:0]          cap_rdata;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic                 sel_write;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_strb;

    // A client that is being acknowledged must not be picked up again.
    assign eligible = {req1 & ~ack1, req0 & ~ack0};

    cmsdk_apb4_rr_arb2 u_rr (
        .eligible   (eligible),
        .last_grant (last_grant),
        .valid      (rr_valid),
        .grant      (rr_grant)
    );

    assign sel_addr  = rr_grant ? addr1  : addr0;
    assign sel_write = rr_grant ? write1 : write0;
    assign sel_wdata = rr_grant ? wdata1 : wdata0;
    assign sel_strb  = rr_grant ? strb1  : strb0;

`ifdef APB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;

    assign timed_out = ~pready &&
                       (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            to_cnt <= '0;
        end else if (state == IDLE && rr_valid) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            to_cnt <= to_cnt + TO_CNT_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign finish    = pready | timed_out;
    assign cap_rdata = (timed_out | pwrite) ? 32'h0 : prdata;
    assign cap_err   = timed_out | pslverr;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            psel       <= 1'b0;
            penable    <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rr_valid) begin
                        grant  <= rr_grant;
                        paddr  <= sel_addr;
                        pwrite <= sel_write;
                        pwdata <= sel_wdata;
                        pstrb  <= sel_write ? sel_strb : 4'h0;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (finish) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= DONE;
                        if (grant) begin
                            ack1   <= 1'b1;
                            rdata1 <= cap_rdata;
                            err1   <= cap_err;
                        end else begin
                            ack0   <= 1'b1;
                            rdata0 <= cap_rdata;
                            err0   <= cap_err;
                        end
                    end
                end
                DONE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cmsdk_apb4_eg_arbiter.md
Name: cmsdk_apb4_eg_arbiter

Overview:
Two-requester APB4 master-side arbiter/sequencer that shares a single APB4 slave (e.g. the example slave register interface) between two simple request/acknowledge register-access clients. The block performs round-robin arbitration and drives the APB4 SETUP/ACCESS sequence, including wait states. It returns read data and error status to the granted client. It sits between bus-side agents (debug/DMA-style masters) and the APB slave port.

Parameters:
ADDRWIDTH, 12, width of paddr and client addresses
TIMEOUT_CYCLES, 255, ACCESS-phase cycles without pready before abort (used only with the optional feature; 1..255)

Ports:
pclk  input  1  clock
presetn  input  1  reset, asynchronous, active-low
req0 / req1  input  1  client n requests a transfer; held until ackn
addr0 / addr1  input  ADDRWIDTH  client n address
write0 / write1  input  1  1 = write, 0 = read
wdata0 / wdata1  input  32  client n write data
strb0 / strb1  input  4  client n byte strobes
ack0 / ack1  output  1  one-cycle completion pulse to client n
rdata0 / rdata1  output  32  read data to client n, valid while ackn = 1
err0 / err1  output  1  error status to client n, valid while ackn = 1
psel  output  1  APB select
penable  output  1  APB enable
paddr  output  ADDRWIDTH  APB address
pwrite  output  1  APB direction
pwdata  output  32  APB write data
pstrb  output  4  APB strobes; forced to 0 on reads
prdata  input  32  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = 1, so client 0 wins the first tie. Async assertion mid-transfer drops psel/penable immediately; no ack is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: eligible_n = reqn & ~ackn.
  - If any client is eligible, register grant and latch addr/write/wdata/strb into paddr/pwrite/pwdata/pstrb; go to SETUP.
  - Tie: grant the client not equal to last_grant.
- SETUP (psel=1, penable=0): always go to ACCESS.
- ACCESS (psel=1, penable=1):
  - pready=0: stay in ACCESS; all APB outputs stay stable.
  - pready=1: capture prdata (reads; 0 for writes) and pslverr into the grant's rdata/err; go to DONE.
- DONE: psel=penable=0; ack[grant]=1 for exactly this cycle; last_grant <= grant; next state IDLE.
  - The completed client must drop req in the cycle after ack. The eligible mask prevents re-grant during the ack cycle.
- Latency: req rises in cycle N while IDLE → SETUP at N+1 → ACCESS at N+2 → with zero wait states, ack at N+3. Each wait state adds 1 cycle.
- Each transfer is 4 cycles minimum. psel is low for at least one cycle (DONE) between transfers.
- rdata/err of the non-granted client hold their previous value.
- A req change on a non-granted client during a transfer has no effect until IDLE.
- The latched transfer attributes are insensitive to changes on the client bus after the grant.
- Simultaneous req0=req1=1 in IDLE gives strict alternation across consecutive transfers.

Optional Feature:
APB_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on SETUP entry and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES while pready=0, go to DONE with errn=1 and rdatan=0. psel/penable drop in DONE.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Shared package cmsdk_apb4_eg_arb_pkg: state encoding constants (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3) and the timeout counter width (8).
- One sub-module, cmsdk_apb4_rr_arb2: combinational 2-way round-robin grant from eligible[1:0] and last_grant, with a registered last_grant input.
- The FSM and datapath stay in the top module.

Test Plan:
- Single read: req0 with addr0=12'h010, prdata=32'hCAFE_0001, pready=1 → psel at N+1, penable at N+2, ack0 at N+3 with rdata0=32'hCAFE_0001, err0=0.
- Write with 2 wait states: req1 with addr1=12'h004, wdata1=32'h1234_5678, strb1=4'b0011 → APB fields stable through 3 ACCESS cycles, ack1 at N+5, pstrb=0011.
- Contention: req0=req1=1 held for 4 transfers, each dropped after its ack → grant order 0,1,0,1; no back-to-back grant to the same client.
- Error: pslverr=1 with pready=1 on a client-1 read → err1=1 in the ack1 cycle; client-0 outputs unchanged.
- Reset in ACCESS: presetn low during a wait state → psel, penable, ack low asynchronously. After release, state IDLE and the first tie goes to client 0.
- APB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and pready held 0 → ack0 with err0=1, rdata0=0, after 4 ACCESS cycles. Without the macro, ack never arrives.
